lvds_word_serializer: RTL
=========================

# lvds_word_serializer

Serializes parallel frame words into a single-lane LVDS data stream with a forwarded bit clock. It sits directly downstream of the frame builder, which produces 32-bit I/Q frame words, and drives the `tx_a` / `clk_a` pads. A one-word holding buffer lets the upstream stage present the next frame while the current one is shifting out, so consecutive words go out with no gap on the line.

## Interface
- `WIDTH`, 32: bits per word; ≥ 2.
- `DIV`, 2: `clk` cycles per serial bit; even, ≥ 2.
- `clk`  in  1  serializer clock (64 MHz domain); all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_data`  in  WIDTH  word to send, MSB first.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  holding buffer is empty; a word is accepted on a rising edge where `in_valid & in_ready`.
- `tx_a`  out  1  serial data, registered.
- `clk_a`  out  1  forwarded bit clock, registered. The receiver samples `tx_a` on the rising edge of `clk_a`.
- `busy`  out  1  shifter holds a word in flight.
- `word_done`  out  1  one-cycle pulse when the last bit of a word completes.
- `word_cnt`  out  16  count of completed words; wraps from 0xFFFF to 0.

## Operation
- Storage: holding buffer `buf` with flag `buf_full`; shift register `sh`; bit index `0..WIDTH-1`; phase counter `0..DIV-1`.
- `in_ready = ~buf_full & ~reset`. Accepting a word sets `buf_full` and stores `in_data`.
- A word is never accepted and loaded into the shifter in the same cycle, because `in_ready` is low whenever `buf_full` is set.
- States:
  - IDLE: `busy=0`, `tx_a=0`, `clk_a=0` (see Configuration).
  - SHIFT: `busy=1`.
- IDLE → SHIFT when `buf_full`. On that edge: `sh<=buf`, `buf_full<=0`, `tx_a<=buf[WIDTH-1]`, phase 0, bit 0.
- In SHIFT, each bit is held for DIV cycles:
  - `clk_a=0` for phases `0..DIV/2-1`.
  - `clk_a=1` for phases `DIV/2..DIV-1`.
- At phase DIV-1 of bit k < WIDTH-1: shift left and present the next bit.
- At phase DIV-1 of bit WIDTH-1, on the edge that ends the word:
  - `word_done` pulses and `word_cnt` increments.
  - If `buf_full`: load the next word exactly as in IDLE → SHIFT and stay in SHIFT (seamless).
  - Otherwise: go to IDLE with `tx_a<=0`.
- Reset mid-operation: every register clears immediately. The partial word and the buffered word are discarded, and nothing is replayed.

## Timing
- Reset values:
  - `tx_a`=0, `clk_a`=0, `busy`=0, `word_done`=0, `word_cnt`=0.
  - `in_ready`=0 while `reset` is high; 1 on the first edge after release.
- Latency: when a word is accepted on edge E with the shifter idle, its MSB appears on `tx_a` after edge E+1.
- Word duration: WIDTH·DIV cycles. `word_done` is high for the cycle after the final bit period.
- Back-to-back: the MSB of the next word follows the LSB of the previous word on the adjacent bit slot, with no idle bit.
- `clk_a` rising edges fall at mid-bit. Data changes only when `clk_a` is low, so there is DIV/2 cycles of setup and hold on each side.
- Throughput: at most one word per WIDTH·DIV cycles. `in_ready` is high again one cycle after the buffer drains into the shifter.

## Configuration
- `LVDS_IDLE_CLK_EN` defined: the phase counter runs freely in IDLE and `clk_a` keeps toggling with period DIV. The first word's load waits for phase DIV-1, so bit slots stay aligned to the free-running clock; latency is then 2..DIV+1 cycles. `tx_a` stays 0 in IDLE.
- `LVDS_IDLE_CLK_EN` undefined: `clk_a` is held 0 in IDLE and the load is immediate, as in Timing.

## Test plan
- **Single word.** DIV=2, send 0xA5A50F0F once.
  - `tx_a` carries bit pairs 1,1,0,0,1,1,0,0… MSB first, starting 2 edges after accept.
  - `word_done` pulses once, 64 cycles later; `word_cnt`=1.
  - `busy` and `tx_a` return to 0.
- **Back-to-back.** 0xFFFF0000 then 0x0000FFFF offered on consecutive cycles.
  - Second is accepted while the first shifts.
  - 128 contiguous bit cycles with no gap.
  - Two `word_done` pulses 64 cycles apart.
- **Backpressure.** `in_valid` held high with three words.
  - `in_ready` drops after the second accept.
  - Third word is accepted only after the first word_done/load.
  - Order on `tx_a` is preserved.
- **Reset mid-word.** Assert `reset` at bit 10 of a word, with one word buffered.
  - All outputs go to reset values asynchronously.
  - After release, nothing is transmitted until a new word arrives; `word_cnt`=0.
- **Idle clock.** With `LVDS_IDLE_CLK_EN`, DIV=4:
  - `clk_a` toggles 2 low / 2 high while idle.
  - The first MSB starts on a phase-0 boundary.
  - Without the macro, `clk_a` stays 0 while idle.
- **Counter wrap.** Preload 0xFFFF via a force, send one word: `word_cnt`=0x0000.

Source files
------------

// File: rtl/lvds_word_serializer.sv
// lvds_word_serializer
//
// Serializes parallel frame words MSB first onto a single LVDS data lane
// (tx_a) together with a forwarded bit clock (clk_a). A one-word holding
// buffer decouples the upstream frame builder from the shifter, so a word
// that is waiting in the buffer goes out directly after the one in flight,
// with no idle bit between them.
//
// Each serial bit lasts DIV clk cycles. clk_a is low for the first half of
// the bit and high for the second half. Its rising edge therefore falls
// mid-bit, and tx_a only changes while clk_a is low.
//
// Optional feature (compile-time macro LVDS_IDLE_CLK_EN):
//   defined   - clk_a keeps toggling while idle. A new word is loaded only on
//               a bit-slot boundary of that free-running clock.
//   undefined - clk_a is held low while idle, and a buffered word is loaded
//               on the next edge.
//
// Ports:
//   clk        serializer clock; all logic runs on its rising edge
//   reset      asynchronous, active-high reset
//   in_data    word to send (WIDTH bits, MSB first on the line)
//   in_valid   in_data is valid
//   in_ready   holding buffer is empty; accept on in_valid & in_ready
//   tx_a       registered serial data
//   clk_a      registered forwarded bit clock
//   busy       shifter holds a word in flight
//   word_done  one-cycle pulse after the last bit of a word
//   word_cnt   completed-word counter, wraps 0xFFFF -> 0
module lvds_word_serializer #(
  parameter int WIDTH = 32,
  parameter int DIV   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tx_a,
  output logic             clk_a,
  output logic             busy,
  output logic             word_done,
  output logic [15:0]      word_cnt
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);
  localparam logic [PW-1:0] PH_HALF  = PW'(DIV / 2);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] buf_reg, buf_next;
  logic             buf_full_reg, buf_full_next;
  logic [WIDTH-1:0] sh_reg, sh_next;
  logic [BW-1:0]    bit_reg, bit_next;
  logic [PW-1:0]    phase_reg, phase_next;
  logic             tx_reg, tx_next;
  logic             clk_a_reg, clk_a_next;
  logic             done_reg, done_next;
  logic [15:0]      cnt_reg, cnt_next;
  logic             accept;
  logic             load;
  logic             phase_wrap;

  // The buffer never accepts a word while it is full. A load into the
  // shifter always requires a full buffer, so accept and load can never
  // occur in the same cycle.
  assign in_ready   = ~buf_full_reg & ~reset;
  assign accept     = in_valid & in_ready;
  assign phase_wrap = (phase_reg == PH_LAST);

  assign tx_a      = tx_reg;
  assign clk_a     = clk_a_reg;
  assign busy      = (state_reg == SHIFT);
  assign word_done = done_reg;
  assign word_cnt  = cnt_reg;

  always_comb begin
    state_next    = state_reg;
    buf_next      = buf_reg;
    buf_full_next = buf_full_reg;
    sh_next       = sh_reg;
    bit_next      = bit_reg;
    phase_next    = phase_reg;
    tx_next       = tx_reg;
    done_next     = 1'b0;
    cnt_next      = cnt_reg;
    load          = 1'b0;

    case (state_reg)
      IDLE: begin
        tx_next = 1'b0;
`ifdef LVDS_IDLE_CLK_EN
        // Free-running phase: only load on a slot boundary so the first bit
        // lines up with the clock the receiver is already seeing.
        phase_next = phase_wrap ? '0 : phase_reg + 1'b1;
        load       = buf_full_reg & phase_wrap;
`else
        phase_next = '0;
        load       = buf_full_reg;
`endif
      end
      SHIFT: begin
        if (!phase_wrap) begin
          phase_next = phase_reg + 1'b1;
        end else if (bit_reg != BIT_LAST) begin
          phase_next = '0;
          bit_next   = bit_reg + 1'b1;
          sh_next    = sh_reg << 1;
          tx_next    = sh_reg[WIDTH-2];
        end else begin
          // End of the final bit period of the word.
          done_next = 1'b1;
          cnt_next  = cnt_reg + 16'd1;
          load      = buf_full_reg;
          if (!buf_full_reg) begin
            state_next = IDLE;
            tx_next    = 1'b0;
            phase_next = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Loading from the buffer is identical from IDLE and at the end of a word.
    // Reusing it at the end of a word is what makes back-to-back words seamless.
    if (load) begin
      state_next    = SHIFT;
      sh_next       = buf_reg;
      tx_next       = buf_reg[WIDTH-1];
      phase_next    = '0;
      bit_next      = '0;
      buf_full_next = 1'b0;
    end

    if (accept) begin
      buf_next      = in_data;
      buf_full_next = 1'b1;
    end

    // clk_a is registered from the upcoming phase, so it is aligned with
    // the registered tx_a.
`ifdef LVDS_IDLE_CLK_EN
    clk_a_next = (phase_next >= PH_HALF);
`else
    clk_a_next = (state_next == SHIFT) && (phase_next >= PH_HALF);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      buf_reg      <= '0;
      buf_full_reg <= 1'b0;
      sh_reg       <= '0;
      bit_reg      <= '0;
      phase_reg    <= '0;
      tx_reg       <= 1'b0;
      clk_a_reg    <= 1'b0;
      done_reg     <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      buf_reg      <= buf_next;
      buf_full_reg <= buf_full_next;
      sh_reg       <= sh_next;
      bit_reg      <= bit_next;
      phase_reg    <= phase_next;
      tx_reg       <= tx_next;
      clk_a_reg    <= clk_a_next;
      done_reg     <= done_next;
      cnt_reg      <= cnt_next;
    end
  end

endmodule
